prog_loader: RTL
================

# prog_loader

Byte-stream program loader that fills the instruction memory before the core is released. Receives a framed byte stream over a valid/ready handshake: 4-byte little-endian length, payload, XOR checksum. Issues one byte-wide write per payload byte into the byte-addressed instruction store at ascending addresses from 0. Payload byte k lands at address k, so a 32-bit word read at address A assembles bytes A+3..A in little-endian order. Reports done or error to the top level, which holds the core in reset while `busy` is high.

## Interface
- ADDRESS_WIDTH, 32, width of `waddr`.
- DATA_WIDTH, 8, width of the stream byte and the write data.
- MEM_BYTES, 4096, instruction store capacity in bytes; maximum legal length.

- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- start  in  1  begin a load; sampled only in IDLE, DONE or ERR.
- rx_valid  in  1  stream byte valid.
- rx_data  in  DATA_WIDTH  stream byte.
- rx_ready  out  1  loader accepts a byte; handshake = rx_valid & rx_ready.
- we  out  1  instruction store byte write enable, one-cycle pulse.
- waddr  out  ADDRESS_WIDTH  byte write address, zero-extended.
- wdata  out  DATA_WIDTH  byte write data.
- busy  out  1  high in LEN, DATA, CSUM.
- done  out  1  load completed with a good checksum; sticky.
- error  out  1  load failed (oversize or bad checksum); sticky.

## Operation
- States: IDLE, LEN, DATA, CSUM, DONE, ERR.
- IDLE: rx_ready=0. On `start`, go to LEN; clear len, ptr, csum, done, error.
- LEN: rx_ready=1. Accept 4 bytes; byte i goes to len[8i+7:8i]. After the 4th handshake:
  - len > MEM_BYTES: go to ERR.
  - len == 0: go to CSUM.
  - otherwise: go to DATA.
- DATA: rx_ready=1. Each handshake does the following:
  - Schedules a write of rx_data to address ptr.
  - Sets ptr <= ptr+1 and csum <= csum ^ rx_data.
  - After the len-th byte, go to CSUM.
- CSUM: rx_ready=1. One handshake:
  - rx_data == csum: go to DONE.
  - otherwise: go to ERR.
- DONE: done=1, rx_ready=0. `start` begins a new load exactly as from IDLE.
- ERR: error=1, rx_ready=0. `start` begins a new load exactly as from IDLE.
- `start` in LEN, DATA or CSUM is ignored.
- len == MEM_BYTES is legal; the last write goes to address MEM_BYTES-1. `ptr` never wraps.
- Bytes offered with rx_ready=0 are not consumed and have no effect.

## Timing
- Reset (asynchronous, immediate): state=IDLE. All outputs 0, including we. len, ptr and csum are 0.
- Reset mid-load aborts immediately; no further writes are issued. Instruction store contents are then unspecified.
- Write latency: a DATA handshake at edge n gives we=1, waddr=ptr, wdata=byte for exactly the cycle after edge n. we falls at edge n+1 unless another handshake occurred at edge n.
- Back-to-back: one byte per cycle with continuous rx_valid, giving consecutive we pulses at consecutive addresses.
- The write for the last payload byte is issued while in CSUM, before done can rise.
- rx_ready depends on state only, never on rx_valid.
- done/error rise the cycle after the deciding handshake:
  - 4th length byte, for oversize.
  - checksum byte, for DONE or ERR.
- busy falls in that same cycle.
- done and error are never high together.

## Test plan
- Normal load:
  - Stimulus: start, then 04 00 00 00 93 00 50 00 C3.
  - Required: 4 we pulses, (addr, data) = (0,93), (1,00), (2,50), (3,00). Then done=1, error=0, busy=0.
- Bad checksum:
  - Stimulus: same frame with checksum 00.
  - Required: the same 4 writes, then error=1, done=0.
- Zero length:
  - Stimulus: 00 00 00 00 00.
  - Required: no we pulses; done=1.
- Oversize:
  - Stimulus: length bytes 01 10 00 00 (0x1001).
  - Required: error=1 the cycle after the 4th byte; rx_ready=0 afterwards; no we pulses.
  - Repeat with 00 10 00 00 plus a 4096-byte payload and correct checksum: last write at address 0xFFF, then done=1.
- Backpressure and ignored start:
  - Stimulus: rx_valid toggled every other cycle with random junk on rx_data while rx_valid=0; pulse `start` mid-DATA.
  - Required: writes only on handshakes, addresses contiguous, result identical to the normal-load scenario.
- Reset mid-load:
  - Stimulus: assert rst asynchronously after 2 payload bytes, between clock edges.
  - Required: all outputs 0 immediately, no further we pulses. A subsequent full load writes from address 0 and ends with done=1.

Source files
------------

// File: rtl/prog_loader_if.sv
// Byte-stream loader bus: framed input stream, byte-wide instruction store write port
// and load status. The loader is the slave; the surrounding top level is the master.
interface prog_loader_if #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 8
);
  logic                     start;
  logic                     rx_valid;
  logic [DATA_WIDTH-1:0]    rx_data;
  logic                     rx_ready;
  logic                     we;
  logic [ADDRESS_WIDTH-1:0] waddr;
  logic [DATA_WIDTH-1:0]    wdata;
  logic                     busy;
  logic                     done;
  logic                     error;

  modport master (
    output start, rx_valid, rx_data,
    input  rx_ready, we, waddr, wdata, busy, done, error
  );

  modport slave (
    input  start, rx_valid, rx_data,
    output rx_ready, we, waddr, wdata, busy, done, error
  );
endinterface

// File: rtl/prog_loader.sv
// Program loader: parses a length / payload / XOR-checksum byte frame and writes the payload
// into the byte-addressed instruction store from address 0, then reports done or error.
module prog_loader #(
  parameter int unsigned ADDRESS_WIDTH = 32,
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned MEM_BYTES     = 4096
) (
  input  logic          clk,
  input  logic          rst,
  prog_loader_if.slave  bus
);

  typedef enum logic [2:0] {StIdle, StLen, StData, StCsum, StDone, StErr} state_e;

  state_e                   state_q, state_d;
  logic [31:0]              len_q, len_d;
  logic [31:0]              ptr_q, ptr_d;
  logic [1:0]               cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]    csum_q, csum_d;
  logic                     we_q, we_d;
  logic [ADDRESS_WIDTH-1:0] waddr_q, waddr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;

  logic        in_load;
  logic        hs;
  logic        start_ok;
  logic [31:0] len_full;

  assign in_load  = (state_q == StLen) || (state_q == StData) || (state_q == StCsum);
  assign hs       = bus.rx_valid & in_load;
  assign start_ok = bus.start &
                    ((state_q == StIdle) || (state_q == StDone) || (state_q == StErr));

  // Length including the byte currently on the bus, so the 4th byte can be judged at once.
  always_comb begin
    len_full = len_q;
    len_full[8*cnt_q +: 8] = bus.rx_data[7:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle, StDone, StErr: begin
        if (bus.start) state_d = StLen;
      end
      StLen: begin
        if (hs && (cnt_q == 2'd3)) begin
          if (len_full > 32'(MEM_BYTES)) state_d = StErr;
          else if (len_full == 32'd0)    state_d = StCsum;
          else                           state_d = StData;
        end
      end
      StData: begin
        if (hs && ((ptr_q + 32'd1) == len_q)) state_d = StCsum;
      end
      StCsum: begin
        if (hs) state_d = (bus.rx_data == csum_q) ? StDone : StErr;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    bus.rx_ready = in_load;
    bus.busy     = in_load;
    bus.done     = (state_q == StDone);
    bus.error    = (state_q == StErr);
    bus.we       = we_q;
    bus.waddr    = waddr_q;
    bus.wdata    = wdata_q;
  end

  always_comb begin
    len_d   = len_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    we_d    = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (start_ok) begin
      len_d  = '0;
      ptr_d  = '0;
      cnt_d  = '0;
      csum_d = '0;
    end
    if (hs && (state_q == StLen)) begin
      len_d = len_full;
      cnt_d = cnt_q + 2'd1;
    end
    if (hs && (state_q == StData)) begin
      we_d    = 1'b1;
      waddr_d = ADDRESS_WIDTH'(ptr_q);
      wdata_d = bus.rx_data;
      ptr_d   = ptr_q + 32'd1;
      csum_d  = csum_q ^ bus.rx_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      csum_q  <= '0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      len_q   <= len_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule
